matrix_result_streamer: RTL and testbench

//  Downstream drain stage for the matrix multiply engine. On the engine's done

---
 rtl/matrix_result_streamer.sv | 149 ++++++++++++++
 tb/tb_matrix_result_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Drain stage for the matrix multiply engine. On eng_done it snapshots the
// flat C matrix into a local buffer. It then streams the active m x n words
// out in row-major order, so the engine is free to start its next job.
// Optional feature macro: RESULT_HDR_EN. When defined, one header beat
// {16'(m), 16'(n)} goes out ahead of the data beats.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready.
// Once out_valid is high it stays high, and out_data/out_row_end/out_last
// hold stable, until that beat transfers.
module matrix_result_streamer #(
  parameter int MAX_M = 10,
  parameter int MAX_N = 10,
  parameter int DW    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            eng_done,
  input  logic [$clog2(MAX_M+1)-1:0]      m_dim,
  input  logic [$clog2(MAX_N+1)-1:0]      n_dim,
  input  logic [MAX_M*MAX_N*DW-1:0]       c_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   out_data,
  output logic                            out_row_end,
  output logic                            out_last,
  output logic                            busy,
  output logic                            drain_done,
  output logic                            overrun,
  output logic                            dim_err,
  output logic [1:0]                      state_dbg
);

  localparam int MW = $clog2(MAX_M+1);
  localparam int NW = $clog2(MAX_N+1);
  localparam int PW = $clog2(MAX_M*MAX_N+1);
  localparam int CW = MAX_M*MAX_N*DW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HDR    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]    state_q;
  logic [CW-1:0] buf_q;
  logic [MW-1:0] m_q;
  logic [NW-1:0] n_q;
  logic [PW-1:0] idx_q;
  logic [NW-1:0] col_q;
  logic          drain_done_q;
  logic          overrun_q;
  logic          dim_err_q;

  logic [PW-1:0] total;
  logic          dims_ok;
  logic          capture;
  logic          fire;
  logic          last_col;
  logic          last_word;

  // Derived job quantities and handshake qualifiers
  always_comb begin
    total     = PW'(m_q) * PW'(n_q);
    dims_ok   = (m_dim != '0) && (m_dim <= MW'(MAX_M)) &&
                (n_dim != '0) && (n_dim <= NW'(MAX_N));
    capture   = eng_done && dims_ok && (state_q == ST_IDLE);
    fire      = out_valid && out_ready;
    last_col  = (col_q == n_q - NW'(1));
    last_word = (idx_q == total - PW'(1));
  end

  // Output beat: header word, buffered C word, or zero when idle
  always_comb begin
    out_valid   = (state_q != ST_IDLE);
    busy        = (state_q != ST_IDLE);
    out_data    = '0;
    out_row_end = 1'b0;
    out_last    = 1'b0;
    if (state_q == ST_HDR) begin
      out_data = DW'({16'(m_q), 16'(n_q)});
    end else if (state_q == ST_STREAM) begin
      out_data    = buf_q[32'(idx_q)*DW +: DW];
      out_row_end = last_col;
      out_last    = last_word;
    end
  end

  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;
  assign dim_err    = dim_err_q;
  assign state_dbg  = state_q;

  // Snapshot buffer: contents only matter after a capture, so no reset
  always_ff @(posedge clk) begin
    if (capture) buf_q <= c_flat;
  end

  // Job FSM, beat counters and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      col_q        <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      dim_err_q    <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      dim_err_q    <= 1'b0;
      overrun_q    <= eng_done && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (eng_done) begin
            if (dims_ok) begin
              m_q   <= m_dim;
              n_q   <= n_dim;
              idx_q <= '0;
              col_q <= '0;
`ifdef RESULT_HDR_EN
              state_q <= ST_HDR;
`else
              state_q <= ST_STREAM;
`endif
            end else begin
              dim_err_q <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (fire) state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (fire) begin
            if (last_word) begin
              state_q      <= ST_IDLE;
              drain_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + PW'(1);
              col_q <= last_col ? '0 : col_q + NW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer
// Self-checking bench for matrix_result_streamer. A reference queue of
// expected beats is built from the matrix dimensions and the words driven on
// c_flat. Sink beats are popped from that queue and compared against it.
// Honors RESULT_HDR_EN in the same way as the design.
module tb_matrix_result_streamer;

  localparam int MAX_M = 10;
  localparam int MAX_N = 10;
  localparam int DW    = 32;
  localparam int CW    = MAX_M*MAX_N*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          eng_done;
  logic [3:0]    m_dim;
  logic [3:0]    n_dim;
  logic [CW-1:0] c_flat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_row_end;
  logic          out_last;
  logic          busy;
  logic          drain_done;
  logic          overrun;
  logic          dim_err;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  // expected beats: {row_end, last, data}
  logic [DW+1:0] exp_q[$];

  matrix_result_streamer #(.MAX_M(MAX_M), .MAX_N(MAX_N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .eng_done(eng_done), .m_dim(m_dim), .n_dim(n_dim),
    .c_flat(c_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row_end(out_row_end), .out_last(out_last),
    .busy(busy), .drain_done(drain_done), .overrun(overrun),
    .dim_err(dim_err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_M*MAX_N; i++) c_flat[i*DW +: DW] = $urandom;
  endtask

  // drive C and build the reference beat list from the row-major rule
  task automatic load_matrix(input int m, input int n, input bit pattern);
    logic [DW-1:0] w;
    fill_random();
    exp_q.delete();
`ifdef RESULT_HDR_EN
    exp_q.push_back({2'b00, 16'(m), 16'(n)});
`endif
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        w = pattern ? 32'h3F800000 + 32'(r*n + c) : $urandom;
        c_flat[(r*n + c)*DW +: DW] = w;
        exp_q.push_back({(c == n-1), (r == m-1 && c == n-1), w});
      end
    end
  endtask

  // called at a negedge; returns at a negedge
  // rmode: 0 ready=1, 1 toggle 1010.., 2 random
  task automatic run_job(input int m, input int n, input bit pattern, input int rmode,
                         input int ovr_at, input int rst_at);
    int beats, vcycles, nexp;
    bit tog, stall, ovr_pend, ovr_used, done;
    logic [DW+1:0] held, cur, e;
    load_matrix(m, n, pattern);
    nexp = exp_q.size();
    m_dim = 4'(m);
    n_dim = 4'(n);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    check("latency_valid", 64'(out_valid), 64'(1));
    check("busy_set", 64'(busy), 64'(1));
    beats = 0; vcycles = 0; tog = 1'b1; stall = 1'b0;
    ovr_pend = 1'b0; ovr_used = 1'b0; done = 1'b0; held = '0;
    for (int budget = 0; budget < 3000 && !done; budget++) begin
      if (budget > 0) @(negedge clk);
      eng_done = 1'b0;
      if (ovr_pend) begin
        check("overrun_pulse", 64'(overrun), 64'(1));
        ovr_pend = 1'b0;
      end
      cur = {out_row_end, out_last, out_data};
      if (stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_hold", 64'(cur), 64'(held));
      end
      if (rst_at >= 0 && beats == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("rst_no_drain", 64'(drain_done), 64'(0));
          check("rst_idle", 64'(out_valid), 64'(0));
        end
        exp_q.delete();
        done = 1'b1;
      end else begin
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = tog;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid) begin
          vcycles++;
          tog = !tog;
        end
        if (ovr_at >= 0 && !ovr_used && beats == ovr_at && out_valid) begin
          fill_random();
          m_dim = 4'($urandom_range(1, MAX_M));
          n_dim = 4'($urandom_range(1, MAX_N));
          eng_done = 1'b1;
          ovr_pend = 1'b1;
          ovr_used = 1'b1;
        end
        stall = out_valid && !out_ready;
        held  = cur;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
          beats++;
          if (beats == nexp) begin
            @(negedge clk);
            eng_done = 1'b0;
            check("drain_done", 64'(drain_done), 64'(1));
            check("idle_valid", 64'(out_valid), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
            check("no_overrun", 64'(overrun), 64'(0));
            if (rmode == 0) check("valid_cycles", 64'(vcycles), 64'(nexp));
            if (rmode == 1) check("valid_cycles", 64'(vcycles), 64'(2*nexp-1));
            done = 1'b1;
          end
        end else if (!out_valid) begin
          check("valid_drop", 64'(out_valid), 64'(1));
        end
      end
    end
    if (!done) check("timeout", 64'(0), 64'(1));
  endtask

  // called at a negedge; returns at a negedge
  task automatic bad_dims(input int m, input int n);
    m_dim = 4'(m);
    n_dim = 4'(n);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    check("dim_err_pulse", 64'(dim_err), 64'(1));
    check("dim_err_novalid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("dim_err_clear", 64'(dim_err), 64'(0));
    check("dim_err_idle", 64'(busy), 64'(0));
  endtask

  // stimulus and final report
  initial begin
    rst = 1'b1; eng_done = 1'b0; out_ready = 1'b0;
    m_dim = '0; n_dim = '0; c_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy0", 64'(busy), 64'(0));
    check("rst_drain_done", 64'(drain_done), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_dim_err", 64'(dim_err), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_flags", 64'({out_row_end, out_last}), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_job(2, 3, 1'b1, 0, -1, -1);   // back-to-back with the next job
    run_job(2, 3, 1'b1, 1, -1, -1);
    run_job(1, 1, 1'b0, 0, -1, -1);
    bad_dims(0, 3);
    bad_dims(2, 0);
    bad_dims(11, 1);
    bad_dims(1, 11);
    run_job(2, 3, 1'b0, 0, 2, -1);
    run_job(2, 3, 1'b0, 0, -1, 3);
    check("post_rst_state", 64'(state_dbg), 64'(0));
    run_job(3, 2, 1'b0, 0, -1, -1);
    run_job(4, 5, 1'b1, 0, -1, -1);
    run_job(10, 10, 1'b0, 2, -1, -1);
    repeat (6) run_job($urandom_range(1, MAX_M), $urandom_range(1, MAX_N), 1'b0, 2, -1, -1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
